// File: rtl/sdrc_app_responder.sv
// Application-side SDRAM responder: accepts burst commands, writes and reads an internal memory.
// The first read beat arrives RD_LAT cycles after ack. Macro SDRC_RESP_WR_THROTTLE_EN consumes write beats only on alternate cycles.
module sdrc_app_responder #(
  parameter int dw     = 32,
  parameter int bl     = 9,
  parameter int aw     = 8,
  parameter int RD_LAT = 2
) (
  input  logic            sdram_clk,
  input  logic            sdram_resetn,
  input  logic            sdr_req,
  input  logic [29:0]     sdr_req_addr,
  input  logic [bl-1:0]   sdr_req_len,
  input  logic            sdr_req_wr_n,
  output logic            sdr_req_ack,
  output logic            sdr_busy_n,
  input  logic [dw/8-1:0] sdr_wr_en_n,
  input  logic [dw-1:0]   sdr_wr_data,
  output logic            sdr_wr_next,
  output logic            sdr_rd_valid,
  output logic            sdr_last_rd,
  output logic [dw-1:0]   sdr_rd_data
);

  localparam int NB = dw / 8;

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, READ} state_t;

  logic [dw-1:0] mem [2**aw];

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          rd_valid_q, rd_valid_d;
  logic          last_q, last_d;
  logic          phase_q, phase_d;
  logic [dw-1:0] rd_data_q, rd_data_d;
  logic [aw-1:0] ptr_q, ptr_d;
  logic [bl-1:0] len_q, len_d;
  logic [bl-1:0] beat_q, beat_d;
  logic [3:0]    wait_q, wait_d;
  logic          wr_next;
  logic          issue_beat;
  logic          last_beat;
  logic          unused_addr_hi;

  assign last_beat      = (beat_q == len_q - bl'(1));
  assign unused_addr_hi = ^sdr_req_addr[29:aw];

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    rd_valid_d = 1'b0;
    last_d     = 1'b0;
    phase_d    = phase_q;
    rd_data_d  = rd_data_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    wr_next    = 1'b0;
    issue_beat = 1'b0;

    case (state_q)
      IDLE: begin
        if (sdr_req && !ack_q) begin
          ack_d   = 1'b1;
          ptr_d   = sdr_req_addr[aw-1:0];
          len_d   = (sdr_req_len == '0) ? bl'(1) : sdr_req_len;
          beat_d  = '0;
          phase_d = 1'b0;
          wait_d  = 4'(RD_LAT - 1);
          state_d = sdr_req_wr_n ? RD_WAIT : WRITE;
        end
      end
      WRITE: begin
`ifdef SDRC_RESP_WR_THROTTLE_EN
        wr_next = !phase_q;
        phase_d = !phase_q;
`else
        wr_next = 1'b1;
`endif
        if (wr_next) begin
          ptr_d  = ptr_q + 1'b1;
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      RD_WAIT: begin
        // The last wait cycle launches beat 0 so it is visible exactly RD_LAT cycles after ack.
        if (wait_q == '0) begin
          issue_beat = 1'b1;
          state_d    = READ;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      READ: begin
        if (last_q) state_d = IDLE;
        else        issue_beat = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (issue_beat) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem[ptr_q];
      last_d     = last_beat;
      ptr_d      = ptr_q + 1'b1;
      beat_d     = beat_q + 1'b1;
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      last_q     <= 1'b0;
      phase_q    <= 1'b0;
      rd_data_q  <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rd_valid_q <= rd_valid_d;
      last_q     <= last_d;
      phase_q    <= phase_d;
      rd_data_q  <= rd_data_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
    end
  end

  // Memory deliberately has no reset so completed beats survive a mid-burst reset.
  always_ff @(posedge sdram_clk) begin
    if (wr_next) begin
      for (int i = 0; i < NB; i++) begin
        if (!sdr_wr_en_n[i]) mem[ptr_q][8*i +: 8] <= sdr_wr_data[8*i +: 8];
      end
    end
  end

  assign sdr_req_ack  = ack_q;
  assign sdr_busy_n   = (state_q == IDLE) && !ack_q;
  assign sdr_wr_next  = wr_next;
  assign sdr_rd_valid = rd_valid_q;
  assign sdr_last_rd  = last_q;
  assign sdr_rd_data  = rd_data_q;

endmodule

// File: tb/tb_sdrc_app_responder.sv
// Randomized bench for sdrc_app_responder against a word-array memory model and cycle arithmetic.
module tb_sdrc_app_responder;
  localparam int RD_LAT = 2;
`ifdef SDRC_RESP_WR_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic        sdram_clk = 1'b0;
  logic        sdram_resetn;
  logic        sdr_req;
  logic [29:0] sdr_req_addr;
  logic [8:0]  sdr_req_len;
  logic        sdr_req_wr_n;
  logic        sdr_req_ack;
  logic        sdr_busy_n;
  logic [3:0]  sdr_wr_en_n;
  logic [31:0] sdr_wr_data;
  logic        sdr_wr_next;
  logic        sdr_rd_valid;
  logic        sdr_last_rd;
  logic [31:0] sdr_rd_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl  [256];
  logic [31:0] wdat [16];
  logic [3:0]  wen  [16];
  logic [31:0] last_dat;

  always #5 sdram_clk = ~sdram_clk;

  sdrc_app_responder #(.dw(32), .bl(9), .aw(8), .RD_LAT(RD_LAT)) dut (
    .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn),
    .sdr_req(sdr_req), .sdr_req_addr(sdr_req_addr), .sdr_req_len(sdr_req_len),
    .sdr_req_wr_n(sdr_req_wr_n), .sdr_req_ack(sdr_req_ack), .sdr_busy_n(sdr_busy_n),
    .sdr_wr_en_n(sdr_wr_en_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_next(sdr_wr_next),
    .sdr_rd_valid(sdr_rd_valid), .sdr_last_rd(sdr_last_rd), .sdr_rd_data(sdr_rd_data)
  );

  task automatic step;
    @(negedge sdram_clk);
  endtask

  function automatic int eff(input int len);
    return (len == 0) ? 1 : len;
  endfunction

  function automatic int wr_cycles(input int l);
    return THR ? 2 * l - 1 : l;
  endfunction

  function automatic logic [31:0] bd(input int k);
    return wdat[k % 16] + 32'(k / 16);
  endfunction

  task automatic mdl_write(input int addr, input int k);
    logic [31:0] d;
    logic [3:0]  en;
    d  = bd(k);
    en = wen[k % 16];
    for (int b = 0; b < 4; b++)
      if (!en[b]) mdl[(addr + k) % 256][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic put_cmd(input int addr, input int len, input bit wr_n);
    logic [31:0] r;
    logic [31:0] a;
    r = $urandom();
    a = addr;
    sdr_req      = 1'b1;
    sdr_req_addr = {r[21:0], a[7:0]};
    sdr_req_len  = 9'(len);
    sdr_req_wr_n = wr_n;
  endtask

  task automatic fill_random(input bit all_en);
    for (int i = 0; i < 16; i++) begin
      wdat[i] = $urandom();
      wen[i]  = all_en ? 4'h0 : 4'($urandom_range(0, 15));
    end
  endtask

  task automatic do_write(input int addr, input int len, input int stop_after);
    int l, k, cyc;
    bit exp_nx;
    l = eff(len);
    k = 0;
    cyc = 0;
    put_cmd(addr, len, 1'b0);
    sdr_wr_data = bd(0);
    sdr_wr_en_n = wen[0];
    checks++;
    if (sdr_busy_n !== 1'b1) begin errors++; $display("FAIL wr_busy_pre: got %b want 1", sdr_busy_n); end
    step;
    checks++;
    if (sdr_req_ack !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b want 1", sdr_req_ack); end
    sdr_req = 1'b0;
    while (k < l && cyc < 2 * l + 4) begin
      sdr_wr_data = bd(k);
      sdr_wr_en_n = wen[k % 16];
      exp_nx = THR ? (cyc % 2 == 0) : 1'b1;
      checks++;
      if (sdr_wr_next !== exp_nx) begin
        errors++; $display("FAIL wr_next cyc=%0d: got %b want %b", cyc, sdr_wr_next, exp_nx);
      end
      if (cyc > 0) begin
        checks++;
        if (sdr_req_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse cyc=%0d: got %b want 0", cyc, sdr_req_ack); end
      end
      if (sdr_wr_next === 1'b1) begin
        mdl_write(addr, k);
        k++;
      end
      step;
      cyc++;
      if (stop_after > 0 && k == stop_after) begin
        sdram_resetn = 1'b0;
        #1;
        checks++;
        if (sdr_busy_n !== 1'b1 || sdr_wr_next !== 1'b0 || sdr_req_ack !== 1'b0) begin
          errors++; $display("FAIL wr_abort: busy_n=%b wr_next=%b ack=%b want 1,0,0", sdr_busy_n, sdr_wr_next, sdr_req_ack);
        end
        step;
        sdram_resetn = 1'b1;
        step;
        return;
      end
    end
    checks++;
    if (k != l) begin errors++; $display("FAIL wr_beats: got %0d want %0d", k, l); end
    checks++;
    if (cyc != wr_cycles(l)) begin errors++; $display("FAIL wr_duration: got %0d want %0d", cyc, wr_cycles(l)); end
    checks++;
    if (sdr_busy_n !== 1'b1 || sdr_wr_next !== 1'b0) begin
      errors++; $display("FAIL wr_end: busy_n=%b wr_next=%b want 1,0", sdr_busy_n, sdr_wr_next);
    end
  endtask

  task automatic do_read(input int addr, input int len);
    int l;
    bit ev, el, eb;
    logic [31:0] ed;
    l = eff(len);
    put_cmd(addr, len, 1'b1);
    checks++;
    if (sdr_busy_n !== 1'b1) begin errors++; $display("FAIL rd_busy_pre: got %b want 1", sdr_busy_n); end
    step;
    checks++;
    if (sdr_req_ack !== 1'b1 || sdr_rd_valid !== 1'b0) begin
      errors++; $display("FAIL rd_ack: ack=%b rd_valid=%b want 1,0", sdr_req_ack, sdr_rd_valid);
    end
    sdr_req = 1'b0;
    for (int t = 1; t <= RD_LAT + l; t++) begin
      step;
      ev = (t >= RD_LAT) && (t < RD_LAT + l);
      el = (t == RD_LAT + l - 1);
      eb = (t == RD_LAT + l);
      checks++;
      if (sdr_rd_valid !== ev) begin errors++; $display("FAIL rd_valid t=%0d: got %b want %b", t, sdr_rd_valid, ev); end
      checks++;
      if (sdr_last_rd !== el) begin errors++; $display("FAIL rd_last t=%0d: got %b want %b", t, sdr_last_rd, el); end
      checks++;
      if (sdr_busy_n !== eb || sdr_req_ack !== 1'b0) begin
        errors++; $display("FAIL rd_busy t=%0d: busy_n=%b ack=%b want %b,0", t, sdr_busy_n, sdr_req_ack, eb);
      end
      if (ev) begin
        ed = mdl[(addr + t - RD_LAT) % 256];
        last_dat = sdr_rd_data;
        checks++;
        if (sdr_rd_data !== ed) begin
          errors++; $display("FAIL rd_data addr=%0h: got %h want %h", (addr + t - RD_LAT) % 256, sdr_rd_data, ed);
        end
      end
    end
  endtask

  task automatic test_reset;
    step;
    sdr_req = 1'b1;
    sdr_req_wr_n = 1'b0;
    step;
    step;
    checks++;
    if (sdr_req_ack !== 1'b0 || sdr_wr_next !== 1'b0 || sdr_rd_valid !== 1'b0 || sdr_last_rd !== 1'b0 ||
        sdr_rd_data !== 32'h0 || sdr_busy_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: ack=%b wr_next=%b rd_valid=%b last=%b rd_data=%h busy_n=%b want 0,0,0,0,0,1",
               sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_last_rd, sdr_rd_data, sdr_busy_n);
    end
    sdr_req = 1'b0;
    sdram_resetn = 1'b1;
    step;
  endtask

  task automatic test_init_mem;
    fill_random(1'b1);
    do_write(0, 256, 0);
    do_read(0, 256);
  endtask

  task automatic test_basic;
    for (int i = 0; i < 16; i++) begin wdat[i] = 32'hA0 + 32'(i); wen[i] = 4'h0; end
    do_write(32'h10, 4, 0);
    do_read(32'h10, 4);
    checks++;
    if (last_dat !== 32'hA3) begin errors++; $display("FAIL basic_last_beat: got %h want 000000a3", last_dat); end
  endtask

  task automatic test_wrap;
    fill_random(1'b1);
    do_write(32'hFE, 4, 0);
    do_read(32'hFE, 4);
    do_read(32'h00, 2);
  endtask

  task automatic test_byte_enable;
    wdat[0] = 32'h11223344; wen[0] = 4'h0;
    do_write(5, 1, 0);
    wdat[0] = 32'hAABBCCDD; wen[0] = 4'b1010;
    do_write(5, 1, 0);
    do_read(5, 1);
    checks++;
    if (last_dat !== 32'h11BB33DD) begin errors++; $display("FAIL byte_enable: got %h want 11bb33dd", last_dat); end
  endtask

  task automatic test_len_zero;
    fill_random(1'b1);
    do_write(32'h40, 0, 0);
    do_read(32'h40, 0);
  endtask

  task automatic test_long_burst;
    fill_random(1'b0);
    do_write(200, 300, 0);
    do_read(200, 300);
  endtask

  task automatic test_random;
    int a, l;
    for (int it = 0; it < 10; it++) begin
      fill_random(it[0]);
      a = $urandom_range(0, 255);
      l = $urandom_range(0, 20);
      do_write(a, l, 0);
      do_read(a, l);
      do_read($urandom_range(0, 255), $urandom_range(1, 8));
    end
  endtask

  task automatic test_back_to_back;
    int la, lb, a, w, wcnt, nbeat, total;
    int acks[$];
    bit eb;
    fill_random(1'b1);
    la = $urandom_range(3, 6);
    lb = $urandom_range(2, 5);
    a  = $urandom_range(0, 255);
    w  = wr_cycles(la);
    wcnt = 0;
    nbeat = 0;
    total = w + 1 + RD_LAT + lb + 1;
    put_cmd(a, la, 1'b0);
    sdr_wr_en_n = 4'h0;
    sdr_wr_data = bd(0);
    step;
    for (int t = 0; t < total; t++) begin
      sdr_wr_data = bd(wcnt);
      if (sdr_req_ack === 1'b1) begin
        acks.push_back(t);
        if (acks.size() == 1) put_cmd(a, lb, 1'b1);
        else sdr_req = 1'b0;
      end
      eb = !(t < w || (t >= w + 1 && t < w + 1 + RD_LAT + lb));
      checks++;
      if (sdr_busy_n !== eb) begin errors++; $display("FAIL b2b_busy t=%0d: got %b want %b", t, sdr_busy_n, eb); end
      if (sdr_wr_next === 1'b1) begin mdl_write(a, wcnt); wcnt++; end
      if (sdr_rd_valid === 1'b1) begin
        checks++;
        if (sdr_rd_data !== mdl[(a + nbeat) % 256] || sdr_last_rd !== (nbeat == lb - 1)) begin
          errors++; $display("FAIL b2b_rd beat=%0d: data=%h last=%b want %h,%b", nbeat, sdr_rd_data, sdr_last_rd,
                             mdl[(a + nbeat) % 256], (nbeat == lb - 1));
        end
        nbeat++;
      end
      step;
    end
    sdr_req = 1'b0;
    checks++;
    if (acks.size() != 2) begin
      errors++; $display("FAIL b2b_ack_count: got %0d want 2", acks.size());
    end else begin
      checks++;
      if (acks[0] != 0 || acks[1] != w + 1) begin
        errors++; $display("FAIL b2b_ack_spacing: got %0d,%0d want 0,%0d", acks[0], acks[1], w + 1);
      end
    end
    checks++;
    if (wcnt != la || nbeat != lb) begin
      errors++; $display("FAIL b2b_beats: wr=%0d rd=%0d want %0d,%0d", wcnt, nbeat, la, lb);
    end
  endtask

  task automatic test_reset_mid_write;
    int a;
    fill_random(1'b1);
    a = $urandom_range(0, 255);
    do_write(a, 8, 3);
    do_read(a, 8);
  endtask

  task automatic test_reset_mid_read;
    int a;
    a = $urandom_range(0, 255);
    put_cmd(a, 8, 1'b1);
    step;
    sdr_req = 1'b0;
    repeat (RD_LAT + 2) step;
    checks++;
    if (sdr_rd_valid !== 1'b1) begin errors++; $display("FAIL rd_mid_burst: got %b want 1", sdr_rd_valid); end
    sdram_resetn = 1'b0;
    #1;
    checks++;
    if (sdr_rd_valid !== 1'b0 || sdr_last_rd !== 1'b0 || sdr_busy_n !== 1'b1 || sdr_rd_data !== 32'h0) begin
      errors++; $display("FAIL rd_abort: rd_valid=%b last=%b busy_n=%b rd_data=%h want 0,0,1,0",
                         sdr_rd_valid, sdr_last_rd, sdr_busy_n, sdr_rd_data);
    end
    step;
    sdram_resetn = 1'b1;
    step;
    do_read(a, 8);
  endtask

  initial begin
    sdram_resetn = 1'b0;
    sdr_req      = 1'b0;
    sdr_req_addr = '0;
    sdr_req_len  = '0;
    sdr_req_wr_n = 1'b1;
    sdr_wr_en_n  = 4'hF;
    sdr_wr_data  = '0;
    last_dat     = '0;
    test_reset;
    test_init_mem;
    test_basic;
    do_read(32'h11, 1);
    test_wrap;
    test_byte_enable;
    test_len_zero;
    test_long_burst;
    test_random;
    test_back_to_back;
    test_reset_mid_write;
    test_reset_mid_read;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdrc_app_responder.md
SDRC_APP_RESPONDER -- requirements
Module: sdrc_app_responder

Interface
REQ-001 The block SHALL have parameter dw, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter bl, default 9, meaning burst-length field width.
REQ-003 The block SHALL have parameter aw, default 8, meaning internal memory word-address width (depth 2**aw).
REQ-004 The block SHALL have parameter RD_LAT, default 2, range 1..15, meaning cycles from ack to first read beat.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, as the following two port lines state.
REQ-006 The block SHALL have port sdram_clk  input  1  the only clock; all logic on its rising edge.
REQ-007 The block SHALL have port sdram_resetn  input  1  asynchronous active-low reset.
REQ-008 The block SHALL have port sdr_req  input  1  command pending (initiator FIFO not empty).
REQ-009 The block SHALL have port sdr_req_addr  input  30  word address of burst start.
REQ-010 The block SHALL have port sdr_req_len  input  bl  burst length in beats; 0 treated as 1.
REQ-011 The block SHALL have port sdr_req_wr_n  input  1  0 write, 1 read.
REQ-012 The block SHALL have port sdr_req_ack  output  1  one-cycle command-accept pulse; pops initiator command FIFO.
REQ-013 The block SHALL have port sdr_busy_n  output  1  1 when idle and able to accept.
REQ-014 The block SHALL have port sdr_wr_en_n  input  dw/8  active-low byte write enables of current write beat.
REQ-015 The block SHALL have port sdr_wr_data  input  dw  current write beat data.
REQ-016 The block SHALL have port sdr_wr_next  output  1  write beat consumed this edge; pops initiator write FIFO.
REQ-017 The block SHALL have port sdr_rd_valid  output  1  sdr_rd_data valid this cycle.
REQ-018 The block SHALL have port sdr_last_rd  output  1  final beat of read burst, coincident with sdr_rd_valid.
REQ-019 The block SHALL have port sdr_rd_data  output  dw  read beat data.

Function
REQ-020 The FSM SHALL have states IDLE, WRITE, RD_WAIT, READ.
REQ-021 In IDLE with sdr_req=1 and sdr_req_ack=0, the next edge SHALL latch addr, len (0->1), wr_n, register sdr_req_ack=1 for exactly one cycle, and go to WRITE (wr_n=0) or RD_WAIT (wr_n=1).
REQ-022 sdr_busy_n SHALL be 1 only in IDLE with sdr_req_ack=0; sdr_req high during any other state SHALL be ignored.
REQ-023 In WRITE, sdr_wr_next SHALL be combinational from state, high on every eligible cycle; at each edge with sdr_wr_next=1, bytes with sdr_wr_en_n[i]=0 SHALL be written to mem[(addr+beat) mod 2**aw], others unchanged.
REQ-024 WRITE SHALL end after len beats; the edge consuming the last beat SHALL return to IDLE.
REQ-025 RD_WAIT SHALL last so that the first sdr_rd_valid is asserted exactly RD_LAT cycles after the sdr_req_ack cycle.
REQ-026 In READ, sdr_rd_valid, sdr_rd_data (= mem[(addr+beat) mod 2**aw]) and sdr_last_rd SHALL be registered outputs, one beat per cycle with no gaps, len beats total.
REQ-027 sdr_last_rd SHALL be 1 only on the final beat; for len=1 it SHALL coincide with the sole beat; it SHALL then return to IDLE.
REQ-028 Address SHALL wrap modulo 2**aw using the low aw bits of sdr_req_addr; upper bits SHALL be ignored.
REQ-029 Beat counter SHALL be bl bits and SHALL not overflow for len up to 2**bl-1.
REQ-030 A command pending on return to IDLE SHALL be acked no earlier than the cycle after IDLE is entered.

Reset
REQ-031 While sdram_resetn=0, state SHALL be IDLE and sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_last_rd SHALL be 0, sdr_rd_data 0, sdr_busy_n 1.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately; memory contents SHALL not be reset and SHALL retain completed beats.

Configuration
REQ-033 With macro SDRC_RESP_WR_THROTTLE_EN defined, sdr_wr_next SHALL be asserted only on alternate WRITE cycles (first WRITE cycle high, then low, high, ...); without it, sdr_wr_next SHALL be high on every WRITE cycle.

Verification
REQ-034 Write addr=0x10, len=4, data 0xA0..0xA3, wr_en_n=0 -> one ack pulse, 4 consecutive wr_next cycles, then read addr=0x10 len=4 returns 0xA0..0xA3, last_rd on 4th beat only.
REQ-035 Read len=1 with RD_LAT=2 -> rd_valid and last_rd both high exactly 2 cycles after ack, for one cycle.
REQ-036 Write addr=0xFE len=4 (aw=8) then read addr=0xFE len=4 -> beats land at 0xFE,0xFF,0x00,0x01 and read back in that order.
REQ-037 Write 0x11223344 to addr 5, then write 0xAABBCCDD with wr_en_n=4'b1010 -> read returns 0x11BB33DD.
REQ-038 sdr_req held high with two queued commands -> acks separated by the full burst plus one IDLE cycle, busy_n low throughout each burst; reset mid-read of len=8 -> rd_valid 0 immediately, busy_n 1.
REQ-039 With SDRC_RESP_WR_THROTTLE_EN, write len=3 -> wr_next pattern 1,0,1,0,1 and correct memory contents.
